// File: rtl/dm_wb_cache_pkg.sv
// Shared types for the direct-mapped write-back cache: FSM states and line geometry.
package cache_types;
  typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} cache_state_t;
  localparam int S_OFFSET = 5;
  localparam int LINE_W   = 256;
  typedef logic [LINE_W-1:0] cache_line_t;
endpackage

// File: rtl/dm_wb_cache_array.sv
// Tag/data/valid/dirty storage with combinational read; fills win over word merges.
// Tags and data are plain flops with no reset; only valid/dirty are cleared by reset_n.
module dm_cache_array
  import cache_types::*;
#(
  parameter int S_INDEX = 3,
  parameter int S_TAG   = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [S_INDEX-1:0] idx,
  input  logic               fill_en,
  input  logic [S_TAG-1:0]   fill_tag,
  input  cache_line_t        fill_line,
  input  logic               wr_en,
  input  logic [2:0]         wr_word,
  input  logic [3:0]         wr_mask,
  input  logic [31:0]        wr_data,
  input  logic               dirty_clr,
  output logic [S_TAG-1:0]   rd_tag,
  output cache_line_t        rd_line,
  output logic               rd_valid,
  output logic               rd_dirty
);
  localparam int SETS = 2 ** S_INDEX;

  logic [S_TAG-1:0] tag_q  [SETS];
  cache_line_t      line_q [SETS];
  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;

  assign rd_tag   = tag_q[idx];
  assign rd_line  = line_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];

  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_q[idx] <= fill_line;
      tag_q[idx]  <= fill_tag;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          line_q[idx][{wr_word, b[1:0], 3'b000} +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[idx] <= 1'b1;
    end else if (dirty_clr) begin
      dirty_q[idx] <= 1'b0;
    end
  end
endmodule

// File: rtl/dm_wb_cache.sv
// Direct-mapped write-back write-allocate L1: hits answer in the presenting cycle;
// misses hold the CPU (no mem_resp) while pmem writes back the victim and fills the line.
module dm_wb_cache
  import cache_types::*;
#(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [3:0]    mem_wmask,
  input  logic [31:0]   mem_address,
  input  logic [31:0]   mem_wdata,
  output logic          mem_resp,
  output logic [31:0]   mem_rdata,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [31:0]   pmem_address,
  output cache_line_t   pmem_wdata,
  input  logic          pmem_resp,
  input  cache_line_t   pmem_rdata
);
  localparam int S_TAG = 32 - S_INDEX - S_OFFSET;

  if (S_OFFSET != cache_types::S_OFFSET) begin : g_offset_chk
    $error("dm_wb_cache supports only 32-byte lines (S_OFFSET=5)");
  end

  cache_state_t       state;
  logic [S_TAG-1:0]   cap_tag;
  logic [S_INDEX-1:0] cap_idx;

  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] req_idx;
  logic [2:0]         req_word;
  logic [1:0]         unused_addr_lsb;
  logic               req, hit, wr_en, fill_en, dirty_clr;
  logic [S_INDEX-1:0] arr_idx;
  logic [S_TAG-1:0]   rd_tag;
  cache_line_t        rd_line;
  logic               rd_valid, rd_dirty;

  assign req_tag         = mem_address[31:S_INDEX+S_OFFSET];
  assign req_idx         = mem_address[S_INDEX+S_OFFSET-1:S_OFFSET];
  assign req_word        = mem_address[4:2];
  assign unused_addr_lsb = mem_address[1:0];

  // During a miss the array is addressed by the captured request, not the live bus.
  assign arr_idx   = (state == CHECK) ? req_idx : cap_idx;
  assign req       = mem_read | mem_write;
  assign hit       = (state == CHECK) && rd_valid && (rd_tag == req_tag);
  assign mem_resp  = req && hit;
  assign wr_en     = mem_resp && mem_write;
  assign mem_rdata = mem_resp ? rd_line[{req_word, 5'b00000} +: 32] : 32'h0;
  assign fill_en   = (state == FILL) && pmem_resp;
  assign dirty_clr = (state == WRITEBACK) && pmem_resp;
  assign pmem_wdata = (state == WRITEBACK) ? rd_line : '0;

  dm_cache_array #(
    .S_INDEX (S_INDEX),
    .S_TAG   (S_TAG)
  ) u_array (
    .clk       (clk),
    .reset_n   (reset_n),
    .idx       (arr_idx),
    .fill_en   (fill_en),
    .fill_tag  (cap_tag),
    .fill_line (pmem_rdata),
    .wr_en     (wr_en),
    .wr_word   (req_word),
    .wr_mask   (mem_wmask),
    .wr_data   (mem_wdata),
    .dirty_clr (dirty_clr),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CHECK;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      cap_tag      <= '0;
      cap_idx      <= '0;
    end else begin
      case (state)
        CHECK: begin
          if (req && !hit) begin
            cap_tag <= req_tag;
            cap_idx <= req_idx;
            if (rd_valid && rd_dirty) begin
              state        <= WRITEBACK;
              pmem_write   <= 1'b1;
              pmem_address <= {rd_tag, req_idx, {S_OFFSET{1'b0}}};
            end else begin
              state        <= FILL;
              pmem_read    <= 1'b1;
              pmem_address <= {req_tag, req_idx, {S_OFFSET{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state        <= FILL;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= {cap_tag, cap_idx, {S_OFFSET{1'b0}}};
          end
        end
        FILL: begin
          if (pmem_resp) begin
            state        <= CHECK;
            pmem_read    <= 1'b0;
            pmem_address <= '0;
          end
        end
        default: state <= CHECK;
      endcase
    end
  end

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n) !(mem_read && mem_write));
endmodule

// File: tb/tb_dm_wb_cache.sv
// Bench for dm_wb_cache: directed table, reset/idle-resp corner sequences, then random traffic
// against a flat-memory + per-set residency reference model and a latency-programmable pmem.
module tb_dm_wb_cache;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         mem_read, mem_write;
  logic [3:0]   mem_wmask;
  logic [31:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  dm_wb_cache dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic         w;
    logic [31:0]  a;
    logic [255:0] d;
  } pm_txn_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_npm;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int pmem_lat = 3;
  int overlap = 0;
  int rsp_cnt = 0;
  int inj_req = 0;
  int inj_ack = 0;
  pm_txn_t logq[$];
  logic [255:0] wb_last;

  logic [255:0] pm   [logic [31:0]];
  logic [31:0]  refw [logic [31:0]];
  logic         mv [8];
  logic         md [8];
  logic [23:0]  mt [8];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] gen_word(input logic [31:0] la, input int i);
    return 32'h1000_0000 + 32'(i) + (la ^ 32'h40);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] wa);
    if (refw.exists(wa)) return refw[wa];
    return gen_word({wa[31:5], 5'b0}, int'(wa[4:2]));
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = ref_word(la + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [255:0] pm_line(input logic [31:0] la);
    logic [255:0] l;
    if (pm.exists(la)) return pm[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = gen_word(la, i);
    return l;
  endfunction

  // Backing memory: answers each pmem request after pmem_lat cycles of it being held.
  initial begin
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) overlap++;
      if (inj_req != inj_ack) begin
        inj_ack++;
        pmem_resp = 1'b1;
        pmem_rdata = {8{32'hDEAD_BEEF}};
        rsp_cnt = 0;
      end else if (reset_n && (pmem_read || pmem_write)) begin
        rsp_cnt++;
        if (rsp_cnt >= pmem_lat) begin
          rsp_cnt = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            pm[pmem_address] = pmem_wdata;
            wb_last = pmem_wdata;
            logq.push_back('{1'b1, pmem_address, pmem_wdata});
          end else begin
            pmem_rdata = pm_line(pmem_address);
            logq.push_back('{1'b0, pmem_address, pmem_rdata});
          end
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask, output int lat, output logic [31:0] rd,
                        output int npm);
    int sx, exp_lat, exp_npm, k;
    logic [23:0] tg;
    logic [31:0] la, wa, exp_rd, vla, nw;
    logic hit, dmiss, got;
    sx = int'(addr[7:5]);
    tg = addr[31:8];
    la = {addr[31:5], 5'b0};
    wa = {addr[31:2], 2'b0};
    hit = mv[sx] && (mt[sx] == tg);
    dmiss = !hit && mv[sx] && md[sx];
    vla = {mt[sx], addr[7:5], 5'b0};
    exp_lat = hit ? 0 : (dmiss ? 2 * pmem_lat + 1 : pmem_lat + 1);
    exp_npm = hit ? 0 : (dmiss ? 2 : 1);
    exp_rd = ref_word(wa);
    logq.delete();
    @(negedge clk);
    mem_read = !we;
    mem_write = we;
    mem_address = addr;
    mem_wdata = wdata;
    mem_wmask = mask;
    lat = 0;
    got = 1'b0;
    rd = '0;
    while (!got && lat < 100) begin
      #1;
      if (mem_resp) begin
        got = 1'b1;
        rd = mem_rdata;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    npm = logq.size();
    chk($sformatf("resp_seen@%h", addr), got, 1'b1);
    chk($sformatf("latency@%h", addr), lat, exp_lat);
    if (!we) chk($sformatf("rdata@%h", addr), rd, exp_rd);
    chk($sformatf("pmem_txns@%h", addr), npm, exp_npm);
    if (npm == exp_npm && exp_npm > 0) begin
      k = 0;
      if (dmiss) begin
        chk("wb_is_write", logq[0].w, 1'b1);
        chk("wb_addr", logq[0].a, vla);
        chk("wb_data", logq[0].d, ref_line(vla));
        k = 1;
      end
      chk("fill_is_read", logq[k].w, 1'b0);
      chk("fill_addr", logq[k].a, la);
    end
    if (!hit) begin
      mv[sx] = 1'b1;
      mt[sx] = tg;
      md[sx] = 1'b0;
    end
    if (we) begin
      nw = ref_word(wa);
      for (int b = 0; b < 4; b++) if (mask[b]) nw[b*8 +: 8] = wdata[b*8 +: 8];
      refw[wa] = nw;
      md[sx] = 1'b1;
    end
  endtask

  initial begin
    vec_t tv[12];
    int lat, npm, bad;
    logic [31:0] rd, addr;
    logic we;

    tv[0] = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1, 32'h1000_0000, 4, 1};
    tv[1] = '{1'b1, 32'h0000_0044, 32'hAABB_CCDD, 4'b0011, 1'b0, 32'h0, 0, 0};
    tv[2] = '{1'b0, 32'h0000_0044, 32'h0, 4'h0, 1'b1, 32'h1000_CCDD, 0, 0};
    tv[3] = '{1'b0, 32'h0000_0140, 32'h0, 4'h0, 1'b1, 32'h1000_0100, 7, 2};
    for (int k = 0; k < 8; k++)
      tv[4+k] = '{1'b0, 32'h0000_0140 + 32'(4*k), 32'h0, 4'h0, 1'b1, 32'h1000_0100 + 32'(k), 0, 0};

    for (int s = 0; s < 8; s++) begin
      mv[s] = 1'b0;
      md[s] = 1'b0;
      mt[s] = '0;
    end
    mem_read = 1'b0; mem_write = 1'b0; mem_wmask = '0; mem_address = '0; mem_wdata = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_resp", mem_resp, 1'b0);
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, 32'h0);
    #1 reset_n = 1'b1;

    pmem_lat = 3;
    for (int i = 0; i < 12; i++) begin
      do_req(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].mask, lat, rd, npm);
      chk($sformatf("row%0d_lat", i), lat, tv[i].exp_lat);
      chk($sformatf("row%0d_npm", i), npm, tv[i].exp_npm);
      if (tv[i].chk_rd) chk($sformatf("row%0d_rdata", i), rd, tv[i].exp_rd);
      if (tv[i].exp_npm == 2) chk("row_wb_word1", wb_last[63:32], 32'h1000_CCDD);
    end

    // Reset in the middle of a line fill.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h0000_0240;
    @(negedge clk);
    #1 chk("t4_fill_started", pmem_read, 1'b1);
    #2 reset_n = 1'b0;
    #1 chk("t4_pmem_read_async_drop", pmem_read, 1'b0);
    chk("t4_no_resp", mem_resp, 1'b0);
    @(negedge clk);
    mem_read = 1'b0;
    #2 reset_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      mv[s] = 1'b0;
      md[s] = 1'b0;
    end
    do_req(1'b0, 32'h0000_0140, 32'h0, 4'h0, lat, rd, npm);
    chk("t4_remiss_lat", lat, 4);
    chk("t4_remiss_rdata", rd, 32'h1000_0100);

    // Stray pmem_resp while idle must be ignored.
    idle();
    #2 inj_req++;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 if (mem_resp || pmem_read || pmem_write) bad++;
    end
    chk("t6_idle_quiet", bad, 0);
    do_req(1'b0, 32'h0000_0144, 32'h0, 4'h0, lat, rd, npm);
    chk("t6_still_hit", lat, 0);
    chk("t6_data_intact", rd, 32'h1000_0101);

    for (int n = 0; n < 300; n++) begin
      pmem_lat = $urandom_range(1, 4);
      we = ($urandom_range(0, 9) < 4);
      addr = {22'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 4) == 0) idle();
      do_req(we, addr, $urandom, 4'($urandom_range(0, 15)), lat, rd, npm);
    end
    idle();
    chk("pmem_rd_wr_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
